param_filter_dispatcher: RTL and testbench

Parametrised successor to the fixed six-filter dispatcher in the force pipeline. It buffers incoming neighbour position packets and dispatches each one to exactly one of NUM_FILTERS external filter lanes. Lane selection is round-robin over lanes that hold credit and are not in input cooldown. On the output side it arbitrates the lanes' pair buffers with a per-lane output cooldown and muxes the selected pair to the force evaluator. Credit-based flow control replaces per-filter back-pressure wires.

---
 rtl/param_filter_dispatcher.sv | 236 +++++++++++++++++++++++
 tb/tb_param_filter_dispatcher.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_filter_dispatcher.sv
// Buffers neighbour packets and dispatches each to one credit-holding filter lane, then arbitrates
// the lanes' pair buffers towards the force evaluator. DISPATCH_STATS_EN adds grant/stall counters.
module param_filter_dispatcher #(
    parameter int NUM_FILTERS  = 6,
    parameter int NB_W         = 86,
    parameter int PAIR_W       = 9,
    parameter int FIFO_DEPTH   = 512,
    parameter int FIFO_AFULL   = 480,
    parameter int LANE_CREDITS = 2,
    parameter int IN_COOLDOWN  = 2,
    parameter int OUT_COOLDOWN = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NB_W-1:0]                i_nb_data,
    input  logic                           i_nb_valid,
    output logic                           o_nb_ready,
    output logic                           o_buffer_empty,
    output logic [NB_W-1:0]                o_lane_nb_data,
    output logic [NUM_FILTERS-1:0]         o_lane_nb_valid,
    input  logic [NUM_FILTERS-1:0]         i_lane_credit_ret,
    input  logic [NUM_FILTERS-1:0]         i_lane_out_req,
    output logic [NUM_FILTERS-1:0]         o_lane_rd_en,
    input  logic [NUM_FILTERS*PAIR_W-1:0]  i_lane_rd_data,
    input  logic [NUM_FILTERS-1:0]         i_lane_rd_valid,
    output logic [PAIR_W-1:0]              o_pair_data,
    output logic [NUM_FILTERS-1:0]         o_pair_src,
    output logic                           o_pair_valid,
`ifdef DISPATCH_STATS_EN
    input  logic [$clog2(NUM_FILTERS)-1:0] i_stat_sel,
    output logic [31:0]                    o_stat_cnt,
`endif
    output logic                           o_credit_err
);

    // Handshake: i_nb_valid is a write strobe accepted whenever the buffer is not full; upstream
    // must stop writing while o_nb_ready=0 (AFULL leaves slack). Lanes never stall the dispatcher:
    // a load strobe is only sent to a lane holding credit, and lanes hand credit back by pulse.
    localparam int IDX_W = $clog2(NUM_FILTERS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int CRW   = $clog2(LANE_CREDITS + 1);
    localparam int ICW   = (IN_COOLDOWN  > 0) ? $clog2(IN_COOLDOWN + 1)  : 1;
    localparam int OCW   = (OUT_COOLDOWN > 0) ? $clog2(OUT_COOLDOWN + 1) : 1;

    // Returns {found, index} of the first requester at or after start, wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_FILTERS-1:0] req,
                                               input logic [IDX_W-1:0]       start);
        logic [IDX_W:0] res;
        int             k;
        res = '0;
        for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
            k = int'(start) + i;
            if (k >= NUM_FILTERS) k = k - NUM_FILTERS;
            if (req[k]) res = {1'b1, k[IDX_W-1:0]};
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NUM_FILTERS - 1) ? '0 : idx + 1'b1;
    endfunction

    logic [NB_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            buf_empty;
    logic            buf_full;
    logic            wr_fire;
    logic            in_fire;

    assign buf_empty = (count == '0);
    assign buf_full  = (count == CW'(FIFO_DEPTH));
    assign wr_fire   = i_nb_valid && !buf_full;

    always_comb begin
        count_nxt = count;
        if (wr_fire && !in_fire)      count_nxt = count + 1'b1;
        else if (!wr_fire && in_fire) count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= i_nb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            o_nb_ready     <= 1'b1;
            o_buffer_empty <= 1'b1;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (in_fire) rd_ptr <= rd_ptr + 1'b1;
            count          <= count_nxt;
            o_nb_ready     <= (count_nxt < CW'(FIFO_AFULL));
            o_buffer_empty <= (count_nxt == '0);
        end
    end

    logic [CRW-1:0]         credit [NUM_FILTERS];
    logic [ICW-1:0]         in_cd  [NUM_FILTERS];
    logic [NUM_FILTERS-1:0] in_elig;
    logic [NUM_FILTERS-1:0] cred_full;
    logic [NUM_FILTERS-1:0] in_gnt;
    logic [IDX_W-1:0]       in_ptr;
    logic [IDX_W-1:0]       in_idx;
    logic [IDX_W:0]         in_pick;

    always_comb begin
        for (int k = 0; k < NUM_FILTERS; k++) begin
            in_elig[k]   = (credit[k] != '0) && (in_cd[k] == '0);
            cred_full[k] = (credit[k] == CRW'(LANE_CREDITS));
        end
    end

    assign in_pick = rr_pick(in_elig, in_ptr);
    assign in_idx  = in_pick[IDX_W-1:0];
    assign in_fire = in_pick[IDX_W] && !buf_empty;
    assign in_gnt  = in_fire ? (NUM_FILTERS'(1) << in_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_FILTERS; k++) begin
                credit[k] <= CRW'(LANE_CREDITS);
                in_cd[k]  <= '0;
            end
            in_ptr          <= '0;
            o_lane_nb_valid <= '0;
            o_lane_nb_data  <= '0;
            o_credit_err    <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_FILTERS; k++) begin
                // A grant and a return in the same cycle cancel out.
                if (in_gnt[k] && !i_lane_credit_ret[k])
                    credit[k] <= credit[k] - 1'b1;
                else if (!in_gnt[k] && i_lane_credit_ret[k] && !cred_full[k])
                    credit[k] <= credit[k] + 1'b1;
                if (in_gnt[k])            in_cd[k] <= ICW'(IN_COOLDOWN);
                else if (in_cd[k] != '0) in_cd[k] <= in_cd[k] - 1'b1;
            end
            if (|(i_lane_credit_ret & ~in_gnt & cred_full)) o_credit_err <= 1'b1;
            if (in_fire) begin
                in_ptr         <= rr_next(in_idx);
                o_lane_nb_data <= mem[rd_ptr];
            end
            o_lane_nb_valid <= in_gnt;
        end
    end

    logic [NUM_FILTERS-1:0] req_q;
    logic [NUM_FILTERS-1:0] out_elig;
    logic [NUM_FILTERS-1:0] sel_d1;
    logic [OCW-1:0]         out_cd [NUM_FILTERS];
    logic [IDX_W-1:0]       out_ptr;
    logic [IDX_W-1:0]       out_idx;
    logic [IDX_W:0]         out_pick;
    logic [PAIR_W-1:0]      pair_mux;

    always_comb begin
        for (int k = 0; k < NUM_FILTERS; k++) begin
            out_elig[k] = req_q[k] && (out_cd[k] == '0);
        end
    end

    assign out_pick     = rr_pick(out_elig, out_ptr);
    assign out_idx      = out_pick[IDX_W-1:0];
    assign o_lane_rd_en = out_pick[IDX_W] ? (NUM_FILTERS'(1) << out_idx) : '0;

    always_comb begin
        pair_mux = '0;
        for (int k = 0; k < NUM_FILTERS; k++) begin
            if (sel_d1[k]) pair_mux = i_lane_rd_data[k*PAIR_W +: PAIR_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_FILTERS; k++) out_cd[k] <= '0;
            req_q        <= '0;
            out_ptr      <= '0;
            sel_d1       <= '0;
            o_pair_data  <= '0;
            o_pair_src   <= '0;
            o_pair_valid <= 1'b0;
        end else begin
            req_q <= i_lane_out_req;
            for (int k = 0; k < NUM_FILTERS; k++) begin
                if (o_lane_rd_en[k])       out_cd[k] <= OCW'(OUT_COOLDOWN);
                else if (out_cd[k] != '0) out_cd[k] <= out_cd[k] - 1'b1;
            end
            if (out_pick[IDX_W]) out_ptr <= rr_next(out_idx);
            sel_d1 <= o_lane_rd_en;
            // Lanes answer one cycle after rd_en; data and source hold between strobes.
            if (|(sel_d1 & i_lane_rd_valid)) begin
                o_pair_data  <= pair_mux;
                o_pair_src   <= sel_d1;
                o_pair_valid <= 1'b1;
            end else begin
                o_pair_valid <= 1'b0;
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [31:0] grant_cnt [NUM_FILTERS];
    logic [31:0] stall_cnt;
    logic [31:0] stat_mux;

    // Any select beyond the last lane reads the stall counter.
    always_comb begin
        stat_mux = stall_cnt;
        for (int k = 0; k < NUM_FILTERS; k++) begin
            if (i_stat_sel == IDX_W'(k)) stat_mux = grant_cnt[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_FILTERS; k++) grant_cnt[k] <= '0;
            stall_cnt  <= '0;
            o_stat_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_FILTERS; k++) begin
                if (in_gnt[k] && (grant_cnt[k] != '1)) grant_cnt[k] <= grant_cnt[k] + 1'b1;
            end
            if (!buf_empty && !in_pick[IDX_W] && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            o_stat_cnt <= stat_mux;
        end
    end
`endif

endmodule

// File: tb/tb_param_filter_dispatcher.sv
// Bench for param_filter_dispatcher: 4 lanes, small buffer, table-driven dispatch/readout sequences.
module tb_param_filter_dispatcher;
    localparam int NF           = 4;
    localparam int NB_W         = 16;
    localparam int PAIR_W       = 9;
    localparam int FIFO_DEPTH   = 32;
    localparam int FIFO_AFULL   = 24;
    localparam int LANE_CREDITS = 2;
    localparam int IN_COOLDOWN  = 2;
    localparam int OUT_COOLDOWN = 3;
    localparam int LW           = NF + NB_W;
    localparam int PW           = NF + PAIR_W;

    logic                 clk;
    logic                 rst_n;
    logic [NB_W-1:0]      i_nb_data;
    logic                 i_nb_valid;
    logic                 o_nb_ready;
    logic                 o_buffer_empty;
    logic [NB_W-1:0]      o_lane_nb_data;
    logic [NF-1:0]        o_lane_nb_valid;
    logic [NF-1:0]        i_lane_credit_ret;
    logic [NF-1:0]        i_lane_out_req;
    logic [NF-1:0]        o_lane_rd_en;
    logic [NF*PAIR_W-1:0] i_lane_rd_data;
    logic [NF-1:0]        i_lane_rd_valid;
    logic [PAIR_W-1:0]    o_pair_data;
    logic [NF-1:0]        o_pair_src;
    logic                 o_pair_valid;
    logic                 o_credit_err;

    param_filter_dispatcher #(
        .NUM_FILTERS(NF), .NB_W(NB_W), .PAIR_W(PAIR_W), .FIFO_DEPTH(FIFO_DEPTH),
        .FIFO_AFULL(FIFO_AFULL), .LANE_CREDITS(LANE_CREDITS), .IN_COOLDOWN(IN_COOLDOWN),
        .OUT_COOLDOWN(OUT_COOLDOWN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_nb_data(i_nb_data), .i_nb_valid(i_nb_valid),
        .o_nb_ready(o_nb_ready), .o_buffer_empty(o_buffer_empty),
        .o_lane_nb_data(o_lane_nb_data), .o_lane_nb_valid(o_lane_nb_valid),
        .i_lane_credit_ret(i_lane_credit_ret), .i_lane_out_req(i_lane_out_req),
        .o_lane_rd_en(o_lane_rd_en), .i_lane_rd_data(i_lane_rd_data),
        .i_lane_rd_valid(i_lane_rd_valid), .o_pair_data(o_pair_data), .o_pair_src(o_pair_src),
        .o_pair_valid(o_pair_valid), .o_credit_err(o_credit_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int             n_vec = 0;
    int             n_err = 0;
    logic [LW-1:0]  lane_q[$];
    logic [PW-1:0]  pair_q[$];
    logic [LW-1:0]  lane_exp;
    logic [PW-1:0]  pair_exp;

    typedef struct {
        logic [NB_W-1:0] data;
        int              lane;   // -1: stays buffered
    } in_vec_t;

    typedef struct {
        logic [NF-1:0]     rd_en;
        logic              pv;
        logic [PAIR_W-1:0] pd;
        logic [NF-1:0]     ps;
    } out_vec_t;

    in_vec_t  t1[12];
    in_vec_t  t5[32];
    out_vec_t t4[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_lane_nb_valid != '0) begin
            if (lane_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL lane_unexpected: strobe %b data %0h, none expected (t=%0t)",
                         o_lane_nb_valid, o_lane_nb_data, $time);
            end else begin
                lane_exp = lane_q.pop_front();
                check("lane_strobe", {o_lane_nb_valid, o_lane_nb_data}, lane_exp);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && o_pair_valid) begin
            if (pair_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pair_unexpected: src %b data %0h, none expected (t=%0t)",
                         o_pair_src, o_pair_data, $time);
            end else begin
                pair_exp = pair_q.pop_front();
                check("pair_strobe", {o_pair_src, o_pair_data}, pair_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Advance one cycle; the lane model answers a pop one cycle after rd_en.
    task automatic step();
        logic [NF-1:0] rd_now;
        rd_now = o_lane_rd_en;
        @(posedge clk);
        #1;
        i_lane_rd_valid = rd_now;
    endtask

    task automatic push_lane(input int lane, input logic [NB_W-1:0] d);
        logic [NF-1:0] oh;
        oh = NF'(1) << lane;
        lane_q.push_back({oh, d});
    endtask

    task automatic push_pair(input int lane, input logic [PAIR_W-1:0] d);
        logic [NF-1:0] oh;
        oh = NF'(1) << lane;
        pair_q.push_back({oh, d});
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- test ----------------
    initial begin
        int lane_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int pair_lane[5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 12; i++) begin
            t1[i].data = 16'h1000 + 16'(i);
            t1[i].lane = (i < 8) ? lane_seq[i] : -1;
        end
        for (int i = 0; i < 32; i++) begin
            t5[i].data = 16'h5000 + 16'(i);
            t5[i].lane = (i < 8) ? lane_seq[i] : -1;
        end
        t4[0] = '{4'b0000, 1'b0, 9'h000, 4'b0000};
        t4[1] = '{4'b0001, 1'b0, 9'h000, 4'b0000};
        t4[2] = '{4'b0010, 1'b0, 9'h000, 4'b0000};
        t4[3] = '{4'b0100, 1'b1, 9'h010, 4'b0001};
        t4[4] = '{4'b1000, 1'b1, 9'h011, 4'b0010};
        t4[5] = '{4'b0001, 1'b1, 9'h012, 4'b0100};
        t4[6] = '{4'b0000, 1'b1, 9'h013, 4'b1000};
        t4[7] = '{4'b0000, 1'b1, 9'h010, 4'b0001};
        t4[8] = '{4'b0000, 1'b0, 9'h000, 4'b0000};

        rst_n             = 1'b1;
        i_nb_data         = '0;
        i_nb_valid        = 1'b0;
        i_lane_credit_ret = '0;
        i_lane_out_req    = '0;
        i_lane_rd_valid   = '0;
        for (int k = 0; k < NF; k++) i_lane_rd_data[k*PAIR_W +: PAIR_W] = PAIR_W'(16 + k);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", o_nb_ready, 1);
        check("rst_empty", o_buffer_empty, 1);
        check("rst_lane_valid", o_lane_nb_valid, 0);
        check("rst_rd_en", o_lane_rd_en, 0);
        check("rst_pair_valid", o_pair_valid, 0);
        check("rst_credit_err", o_credit_err, 0);
        rst_n = 1'b1;
        step();

        // Round-robin dispatch until credits run out.
        for (int i = 0; i < 12; i++) begin
            i_nb_valid = 1'b1;
            i_nb_data  = t1[i].data;
            if (t1[i].lane >= 0) push_lane(t1[i].lane, t1[i].data);
            step();
        end
        i_nb_valid = 1'b0;
        repeat (3) step();
        check("t1_lane_q_drained", lane_q.size(), 0);
        check("t1_not_empty", o_buffer_empty, 0);
        check("t1_ready", o_nb_ready, 1);

        // Lane 2 credit return, then grant+return in the same cycle, then cooldown.
        i_lane_credit_ret = 4'b0100;
        push_lane(2, 16'h1008);
        step();
        step();
        i_lane_credit_ret = '0;
        check("t2_grant_lane2", o_lane_nb_valid, 4'b0100);
        push_lane(2, 16'h1009);
        step();
        check("t2_cooldown_a", o_lane_nb_valid, 0);
        step();
        check("t2_cooldown_b", o_lane_nb_valid, 0);
        step();
        check("t2_regrant_lane2", o_lane_nb_valid, 4'b0100);

        // Lane 1: same-cycle grant/return keeps credit, overflow return sets sticky error.
        i_lane_credit_ret = 4'b0010;
        push_lane(1, 16'h100A);
        step();
        step();
        i_lane_credit_ret = '0;
        check("t3_grant_lane1", o_lane_nb_valid, 4'b0010);
        push_lane(1, 16'h100B);
        step();
        i_lane_credit_ret = 4'b0010;
        step();
        i_lane_credit_ret = '0;
        step();
        check("t3_regrant_lane1", o_lane_nb_valid, 4'b0010);
        check("t3_empty", o_buffer_empty, 1);
        i_lane_credit_ret = 4'b0010;
        step();
        i_lane_credit_ret = '0;
        check("t3_no_err", o_credit_err, 0);
        i_lane_credit_ret = 4'b0010;
        step();
        i_lane_credit_ret = '0;
        check("t3_err_set", o_credit_err, 1);
        repeat (3) step();
        check("t3_err_sticky", o_credit_err, 1);

        // Pair readout round-robin with output cooldown.
        for (int i = 0; i < 5; i++) push_pair(pair_lane[i], PAIR_W'(16 + pair_lane[i]));
        for (int j = 0; j < 9; j++) begin
            if (j == 0) i_lane_out_req = 4'b1111;
            if (j == 5) i_lane_out_req = 4'b0000;
            check($sformatf("t4_rd_en_%0d", j), o_lane_rd_en, t4[j].rd_en);
            check($sformatf("t4_pair_valid_%0d", j), o_pair_valid, t4[j].pv);
            if (t4[j].pv) begin
                check($sformatf("t4_pair_data_%0d", j), o_pair_data, t4[j].pd);
                check($sformatf("t4_pair_src_%0d", j), o_pair_src, t4[j].ps);
            end
            step();
        end
        check("t4_pair_q_drained", pair_q.size(), 0);

        // Reset mid-stream with 5 packets buffered.
        for (int i = 0; i < 7; i++) begin
            i_nb_valid = 1'b1;
            i_nb_data  = 16'h6000 + 16'(i);
            if (i < 2) push_lane(1, 16'h6000 + 16'(i));
            step();
        end
        i_nb_valid = 1'b0;
        check("t6_lane_q_drained", lane_q.size(), 0);
        check("t6_not_empty", o_buffer_empty, 0);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_empty", o_buffer_empty, 1);
        check("t6_rst_ready", o_nb_ready, 1);
        check("t6_rst_lane_valid", o_lane_nb_valid, 0);
        check("t6_rst_lane_data", o_lane_nb_data, 0);
        check("t6_rst_credit_err", o_credit_err, 0);
        check("t6_rst_pair_data", o_pair_data, 0);
        check("t6_rst_pair_src", o_pair_src, 0);
        repeat (2) @(posedge clk);
        #1;
        check("t6_rst_hold_valid", o_lane_nb_valid, 0);
        rst_n = 1'b1;
        step();
        check("t6_post_empty", o_buffer_empty, 1);

        // Fill to the almost-full threshold with credits exhausted, then return credits.
        for (int i = 0; i < 32; i++) begin
            i_nb_valid = 1'b1;
            i_nb_data  = t5[i].data;
            if (t5[i].lane >= 0) push_lane(t5[i].lane, t5[i].data);
            if (i == 31) check("t5_ready_below", o_nb_ready, 1);
            step();
        end
        i_nb_valid = 1'b0;
        check("t5_ready_afull", o_nb_ready, 0);
        step();
        check("t5_ready_hold", o_nb_ready, 0);
        i_lane_credit_ret = 4'b1111;
        for (int k = 0; k < NF; k++) push_lane(k, 16'h5008 + 16'(k));
        step();
        i_lane_credit_ret = '0;
        check("t5_ready_still_low", o_nb_ready, 0);
        step();
        check("t5_ready_reassert", o_nb_ready, 1);
        repeat (5) step();
        check("t5_lane_q_drained", lane_q.size(), 0);
        check("t5_pair_q_drained", pair_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
